// File: rtl/fixed_encode_pkg.sv
// Shared types and constants for the FLAC fixed-predictor subframe encoder.
// The zigzag helper maps a signed residual onto the unsigned Rice domain.
package fixed_encode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARM,
        ST_PARAM,
        ST_RES_Q,
        ST_RES_STOP,
        ST_RES_REM,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [1:0] RICE_METHOD = 2'b00;
    localparam logic [3:0] PART_ORDER  = 4'd0;
    localparam int         RES_W       = 20;
    localparam int         WORD_W      = 16;

    function automatic logic [RES_W-1:0] zigzag(input logic signed [RES_W-1:0] e);
        return (e <<< 1) ^ (e >>> (RES_W - 1));
    endfunction

endpackage

// File: rtl/fixed_encode_bit_packer.sv
// MSB-first bit packer: appends 1..16-bit fields into a 32-bit accumulator and
// emits each completed 16-bit word with its RAM address on the following cycle.
module fixed_encode_bit_packer
    import fixed_encode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [WORD_W-1:0] base_addr,
    input  logic              field_valid,
    input  logic [WORD_W-1:0] field_value,
    input  logic [4:0]        field_len,
    input  logic              flush,
    output logic              not_full,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] word_addr,
    output logic              word_valid
);

    logic [2*WORD_W-1:0] acc;
    logic [4:0]          count;
    logic [WORD_W-1:0]   next_addr;

    logic [WORD_W:0]     ones;
    logic [WORD_W-1:0]   masked;
    logic [2*WORD_W-1:0] placed;
    logic [2*WORD_W-1:0] acc_sum;
    logic [4:0]          cnt_sum;

    // Completed words drain immediately, so the only stall is the flush cycle.
    assign not_full = ~flush;

    always_comb begin
        ones    = (17'd1 << field_len) - 17'd1;
        masked  = field_value & ones[WORD_W-1:0];
        placed  = ({masked, 16'h0000} << (5'd16 - field_len)) >> count;
        acc_sum = acc | placed;
        cnt_sum = count + field_len;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            count      <= '0;
            next_addr  <= '0;
            word       <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (init) begin
                acc       <= '0;
                count     <= '0;
                next_addr <= base_addr;
            end else if (flush) begin
                if (count != 5'd0) begin
                    word       <= acc[2*WORD_W-1:WORD_W];
                    word_addr  <= next_addr;
                    next_addr  <= next_addr + 16'd1;
                    word_valid <= 1'b1;
                end
                acc   <= '0;
                count <= '0;
            end else if (field_valid) begin
                if (cnt_sum >= 5'd16) begin
                    word       <= acc_sum[2*WORD_W-1:WORD_W];
                    word_addr  <= next_addr;
                    next_addr  <= next_addr + 16'd1;
                    word_valid <= 1'b1;
                    acc        <= acc_sum << WORD_W;
                    count      <= cnt_sum - 5'd16;
                end else begin
                    acc   <= acc_sum;
                    count <= cnt_sum;
                end
            end
        end
    end

endmodule

// File: rtl/fixed_encode.sv
// Streaming FLAC fixed-predictor subframe encoder: warm-up samples verbatim,
// a Rice parameter header, then one Rice-coded residual per remaining sample.
module fixed_encode
    import fixed_encode_pkg::*;
#(
    parameter int MAX_ORDER = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [2:0]  iOrder,
    input  logic [3:0]  iRiceParam,
    input  logic [15:0] iBlockSize,
    input  logic [15:0] StartAddr,
    input  logic [15:0] iSample,
    input  logic        iValid,
    output logic        oReady,
    output logic [15:0] oData,
    output logic [15:0] oWriteAddr,
    output logic        oWrEn,
    output logic        oDone,
    output logic [15:0] SamplesRead
);

    localparam int         CAP       = (MAX_ORDER > 4) ? 4 : MAX_ORDER;
    localparam logic [2:0] ORDER_CAP = 3'(CAP);

    state_t state, state_n;

    logic [2:0]         order_q;
    logic [3:0]         k_q;
    logic [15:0]        block_q;
    logic [RES_W-1:0]   q_rem;
    logic [14:0]        r_q;
    logic               q_pend;
    logic signed [15:0] hist [4];

    logic               accept, chunk_emit, more;
    logic [2:0]         order_in;
    logic signed [RES_W-1:0] x0, x1, x2, x3, x4, e;
    logic [RES_W-1:0]   u, q_new;

    logic               pk_init, pk_flush, pk_not_full, f_valid;
    logic [15:0]        f_value;
    logic [4:0]         f_len;

    assign accept   = iValid && oReady;
    assign more     = SamplesRead < block_q;
    assign order_in = (iOrder > ORDER_CAP) ? ORDER_CAP : iOrder;

    always_comb begin
        x0 = {{4{iSample[15]}}, iSample};
        x1 = {{4{hist[0][15]}}, hist[0]};
        x2 = {{4{hist[1][15]}}, hist[1]};
        x3 = {{4{hist[2][15]}}, hist[2]};
        x4 = {{4{hist[3][15]}}, hist[3]};
        case (order_q)
            3'd0:    e = x0;
            3'd1:    e = x0 - x1;
            3'd2:    e = x0 - (x1 <<< 1) + x2;
            3'd3:    e = x0 - ((x1 <<< 1) + x1) + ((x2 <<< 1) + x2) - x3;
            default: e = x0 - (x1 <<< 2) + ((x2 <<< 2) + (x2 <<< 1)) - (x3 <<< 2) + x4;
        endcase
        u     = zigzag(e);
        q_new = u >> k_q;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_n    = state;
        oReady     = 1'b0;
        f_valid    = 1'b0;
        f_value    = '0;
        f_len      = '0;
        pk_init    = 1'b0;
        pk_flush   = 1'b0;
        chunk_emit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iStart) begin
                    pk_init = 1'b1;
                    state_n = (order_in == 3'd0) ? ST_PARAM : ST_WARM;
                end
            end
            ST_WARM: begin
                oReady = pk_not_full;
                if (accept) begin
                    f_valid = 1'b1;
                    f_value = iSample;
                    f_len   = 5'd16;
                    if (SamplesRead + 16'd1 == {13'd0, order_q}) state_n = ST_PARAM;
                end
            end
            ST_PARAM: begin
                if (pk_not_full) begin
                    f_valid = 1'b1;
                    f_value = {6'd0, RICE_METHOD, PART_ORDER, k_q};
                    f_len   = 5'd10;
                    state_n = ST_RES_Q;
                end
            end
            ST_RES_Q: begin
                if (q_pend) begin
                    if (pk_not_full) begin
                        chunk_emit = 1'b1;
                        f_valid    = 1'b1;
                        f_len      = 5'd16;
                        if (q_rem < 20'd32) state_n = ST_RES_STOP;
                    end
                end else begin
                    oReady = pk_not_full;
                    if (accept && q_new < 20'd16) state_n = ST_RES_STOP;
                end
            end
            ST_RES_STOP: begin
                if (pk_not_full) begin
                    f_valid = 1'b1;
                    f_value = 16'd1;
                    f_len   = {1'b0, q_rem[3:0]} + 5'd1;
                    if (k_q != 4'd0) state_n = ST_RES_REM;
                    else             state_n = more ? ST_RES_Q : ST_FLUSH;
                end
            end
            ST_RES_REM: begin
                if (pk_not_full) begin
                    f_valid = 1'b1;
                    f_value = {1'b0, r_q};
                    f_len   = {1'b0, k_q};
                    state_n = more ? ST_RES_Q : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pk_flush = 1'b1;
                state_n  = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state       <= ST_IDLE;
            order_q     <= '0;
            k_q         <= '0;
            block_q     <= '0;
            q_rem       <= '0;
            r_q         <= '0;
            q_pend      <= 1'b0;
            SamplesRead <= '0;
            oDone       <= 1'b0;
        end else begin
            state <= state_n;
            oDone <= (state == ST_DONE);
            if (state == ST_IDLE && iStart) begin
                order_q     <= order_in;
                k_q         <= iRiceParam;
                block_q     <= iBlockSize;
                SamplesRead <= '0;
            end
            if (accept) SamplesRead <= SamplesRead + 16'd1;
            if (state == ST_RES_Q && accept) begin
                q_rem  <= q_new;
                r_q    <= u[14:0];
                q_pend <= (q_new >= 20'd16);
            end else if (chunk_emit) begin
                q_rem  <= q_rem - 20'd16;
                q_pend <= (q_rem >= 20'd32);
            end
        end
    end

    // NOTE: the sample history is pure datapath with no reset; warm-up always
    // refills the taps an order needs before any residual reads them.
    always_ff @(posedge iClk) begin
        if (accept) begin
            hist[0] <= iSample;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    fixed_encode_bit_packer bit_packer (
        .clk         (iClk),
        .rst_n       (iRst),
        .init        (pk_init),
        .base_addr   (StartAddr),
        .field_valid (f_valid),
        .field_value (f_value),
        .field_len   (f_len),
        .flush       (pk_flush),
        .not_full    (pk_not_full),
        .word        (oData),
        .word_addr   (oWriteAddr),
        .word_valid  (oWrEn)
    );

endmodule

// File: tb/tb_fixed_encode.sv
// Scoreboard bench for fixed_encode: each block pushes its hand-computed word
// image, and a monitor pops and compares on every write strobe.
module tb_fixed_encode;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [2:0]  iOrder;
    logic [3:0]  iRiceParam;
    logic [15:0] iBlockSize;
    logic [15:0] StartAddr;
    logic [15:0] iSample;
    logic        iValid;
    logic        oReady;
    logic [15:0] oData;
    logic [15:0] oWriteAddr;
    logic        oWrEn;
    logic        oDone;
    logic [15:0] SamplesRead;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef int vec_t [8];

    wr_t exp_q [$];
    wr_t got_exp;
    int  total = 0;
    int  passed = 0;
    int  done_count = 0;

    always #5 iClk = ~iClk;

    fixed_encode #(.MAX_ORDER(4)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iStart      (iStart),
        .iOrder      (iOrder),
        .iRiceParam  (iRiceParam),
        .iBlockSize  (iBlockSize),
        .StartAddr   (StartAddr),
        .iSample     (iSample),
        .iValid      (iValid),
        .oReady      (oReady),
        .oData       (oData),
        .oWriteAddr  (oWriteAddr),
        .oWrEn       (oWrEn),
        .oDone       (oDone),
        .SamplesRead (SamplesRead)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge iClk) begin
        if (oDone) done_count++;
        if (oWrEn) begin
            if (exp_q.size() == 0) begin
                check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                got_exp = exp_q.pop_front();
                check("wr_addr", 32'(oWriteAddr), 32'(got_exp.addr));
                check("wr_data", 32'(oData), 32'(got_exp.data));
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready", 32'(oReady), 32'd0);
        check("rst_wren", 32'(oWrEn), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_addr", 32'(oWriteAddr), 32'd0);
        check("rst_samples", 32'(SamplesRead), 32'd0);
    endtask

    // Entered and left at a falling edge; the sample is taken on the rising
    // edge where oReady is seen high.
    task automatic send(input int s);
        int n = 0;
        iSample = 16'(s);
        iValid  = 1'b1;
        while (!oReady && n < 200) begin
            @(negedge iClk);
            n++;
        end
        check("ready_wait", 32'(oReady), 32'd1);
        @(negedge iClk);
        iValid = 1'b0;
    endtask

    task automatic run_block(input int order, input int k, input int bsize, input int addr,
                             input vec_t s, input vec_t w, input int nw,
                             input int gap_at, input bit mid_start);
        int n;
        for (int i = 0; i < nw; i++)
            exp_q.push_back('{addr: 16'(addr + i), data: 16'(w[i])});
        iOrder     = 3'(order);
        iRiceParam = 4'(k);
        iBlockSize = 16'(bsize);
        StartAddr  = 16'(addr);
        iStart     = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < bsize; i++) begin
            if (mid_start && i == 2) begin
                iOrder     = 3'd0;
                iRiceParam = 4'd9;
                iBlockSize = 16'd1;
                StartAddr  = 16'h1234;
                iStart     = 1'b1;
                @(negedge iClk);
                iStart = 1'b0;
            end
            if (i == gap_at) begin
                n = 0;
                while (!oReady && n < 200) begin
                    @(negedge iClk);
                    n++;
                end
                for (int g = 0; g < 5; g++) begin
                    @(negedge iClk);
                    check("gap_wren", 32'(oWrEn), 32'd0);
                    check("gap_count", 32'(SamplesRead), 32'(i));
                    check("gap_ready", 32'(oReady), 32'd1);
                end
            end
            send(s[i]);
        end
        n = 0;
        while (!oDone && n < 200) begin
            @(negedge iClk);
            n++;
        end
        check("done_pulse", 32'(oDone), 32'd1);
        check("samples_read", 32'(SamplesRead), 32'(bsize));
        check("words_all_written", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge iClk);
        check("samples_hold", 32'(SamplesRead), 32'(bsize));
    endtask

    initial begin
        vec_t s;
        vec_t w;
        int   dc;
        iRst = 1'b0; iStart = 1'b0; iOrder = '0; iRiceParam = '0; iBlockSize = '0;
        StartAddr = '0; iSample = '0; iValid = 1'b0;
        repeat (2) @(negedge iClk);
        check_reset_outputs();
        iRst = 1'b1;
        @(negedge iClk);

        // Order 0, k=2: mixed-sign residuals spanning a word boundary.
        s = '{1, -1, 2, 0, 0, 0, 0, 0};
        w = '{32'h00B5, 32'h4800, 0, 0, 0, 0, 0, 0};
        run_block(0, 2, 4, 32'h0100, s, w, 2, -1, 1'b0);

        // Order 2, k=0, with a stray iStart mid-block that must be ignored.
        s = '{10, 20, 30, 40, 0, 0, 0, 0};
        w = '{32'h000A, 32'h0014, 32'h0030, 0, 0, 0, 0, 0};
        run_block(2, 0, 4, 32'h0200, s, w, 3, -1, 1'b1);

        // Order 4, k=15, full-scale alternation: e=524280, q=31, r=0x7FF0.
        s = '{32767, -32768, 32767, -32768, 32767, 0, 0, 0};
        w = '{32'h7FFF, 32'h8000, 32'h7FFF, 32'h8000, 32'h03C0, 32'h0000, 32'h007F, 32'hF800};
        run_block(4, 15, 5, 32'h0300, s, w, 8, -1, 1'b0);

        // Order 0, k=0: q=40 (two zero chunks) then q=16 exactly.
        s = '{20, 8, 0, 0, 0, 0, 0, 0};
        w = '{32'h0000, 32'h0000, 32'h0000, 32'h2000, 32'h1000, 0, 0, 0};
        run_block(0, 0, 2, 32'h0400, s, w, 5, -1, 1'b0);

        // Same stream as the first block with a 5-cycle iValid gap.
        s = '{1, -1, 2, 0, 0, 0, 0, 0};
        w = '{32'h00B5, 32'h4800, 0, 0, 0, 0, 0, 0};
        run_block(0, 2, 4, 32'h0500, s, w, 2, 3, 1'b0);

        // Abort during RES_Q: 13 bits pending, nothing may be written.
        dc = done_count;
        iOrder = 3'd0; iRiceParam = 4'd2; iBlockSize = 16'd4; StartAddr = 16'h0600;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        send(1);
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        check_reset_outputs();
        iRst = 1'b1;
        repeat (5) @(negedge iClk);
        check("abort_no_done", 32'(done_count), 32'(dc));
        check("abort_no_words", 32'(exp_q.size()), 32'd0);

        // Fresh block after the abort, with the address wrapping past 0xFFFF.
        s = '{1, -1, 2, 0, 0, 0, 0, 0};
        w = '{32'h00B5, 32'h4800, 0, 0, 0, 0, 0, 0};
        run_block(0, 2, 4, 32'hFFFF, s, w, 2, -1, 1'b0);

        check("done_total", 32'(done_count), 32'd6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fixed_encode.md
# fixed_encode

Streaming FLAC fixed-predictor subframe encoder. It is the write-side counterpart of the fixed-predictor decoder: it produces the word image that the decoder reads.
- Input: one block of signed 16-bit PCM samples through a valid/ready handshake.
- Output: the `iOrder` warm-up samples verbatim, then a Rice residual header, then one Rice-coded residual per remaining sample.
- Packing: MSB-first into 16-bit words, written to RAM from `StartAddr` upward.

## Interface
- `MAX_ORDER`, default 4: highest fixed predictor order supported.
- `iClk`  in  1  clock; all logic on the rising edge.
- `iRst`  in  1  synchronous, active-low reset.
- `iStart`  in  1  one-cycle pulse; latches `iOrder`, `iRiceParam`, `iBlockSize`, `StartAddr`; ignored unless IDLE.
- `iOrder`  in  3  predictor order, 0..4.
- `iRiceParam`  in  4  Rice parameter k, 0..15.
- `iBlockSize`  in  16  samples per block; must satisfy iOrder < iBlockSize.
- `StartAddr`  in  16  first RAM word address.
- `iSample`  in  16  signed PCM sample.
- `iValid`  in  1  iSample valid.
- `oReady`  out  1  encoder accepts iSample this cycle.
- `oData`  out  16  packed word.
- `oWriteAddr`  out  16  address for oData.
- `oWrEn`  out  1  one-cycle write strobe.
- `oDone`  out  1  one-cycle pulse after the last word is written.
- `SamplesRead`  out  16  samples consumed in the current block.

## Operation
- Reset values: oReady=0, oWrEn=0, oDone=0, oData=0, oWriteAddr=0, SamplesRead=0, FSM=IDLE.
- A sample is accepted on a cycle with iValid && oReady. Each accepted sample increments SamplesRead and shifts the history x[n-1..n-4].
- Residual e, computed as 20-bit signed:
  - order 0: x
  - order 1: x - x1
  - order 2: x - 2x1 + x2
  - order 3: x - 3x1 + 3x2 - x3
  - order 4: x - 4x1 + 6x2 - 4x3 + x4
- Zigzag mapping: u = (e<<1) ^ (e>>>19), 20-bit unsigned. Quotient q = u>>k; remainder r = u[k-1:0].
- FSM states and transitions:
  - IDLE → WARM on iStart. WARM emits each of the `order` accepted samples as a 16-bit field. With order 0, WARM is skipped.
  - PARAM emits 10 bits: `00` (method), `0000` (partition order), then k.
  - RES_Q accepts one sample and computes u. While q≥16 it emits 16 zeros per cycle.
  - RES_STOP emits (q mod 16) zeros plus a terminating 1, as a single field of length (q mod 16)+1.
  - RES_REM emits r, length k. It is skipped when k=0.
  - After RES_REM, the FSM returns to RES_Q if SamplesRead < blockSize, otherwise goes to FLUSH.
  - FLUSH writes any partial word, zero-padded in the LSBs. If no bits are pending, it writes nothing.
  - DONE pulses oDone, then returns to IDLE.
- oReady is high only in WARM and RES_Q, and only when the packer can accept a field.
- Every full word is written once. Addresses run StartAddr, StartAddr+1, …, wrapping modulo 2^16.
- iStart is ignored during a block. A reset mid-block aborts immediately; no flush occurs and no oDone is raised.

## Timing
- One packer field (1..16 bits) is accepted per cycle.
- oWrEn is asserted in the cycle after the field that completes a word.
- Residual latency: a sample accepted at cycle t emits its first field at t+1.
- Throughput per residual sample: 1 + ⌊q/16⌋ + 1 + (k>0) cycles.
- oDone is asserted one cycle after the final oWrEn, or two cycles after FLUSH when FLUSH has no pending bits.
- SamplesRead holds its final value until the next iStart, which clears it.

## Structure
- A shared package holds:
  - the FSM state enum;
  - RICE_METHOD = 2'b00;
  - PART_ORDER = 4'd0;
  - RES_W = 20;
  - WORD_W = 16.
- Sub-module `bit_packer` accepts (value[15:0], len[4:0], valid) and raises a not-full indication.
  - It keeps a 32-bit accumulator and a bit count.
  - When the count reaches 16 or more, it outputs the top word with a strobe.
  - A flush input emits the remainder, zero-padded.

## Test plan
- Order 0, k=2, block 4, samples 1,-1,2,0 → writes 0x00B5 at StartAddr and 0x4800 at StartAddr+1; oDone pulses; SamplesRead=4.
- Order 2, k=0, block 4, samples 10,20,30,40 → writes 0x000A, 0x0014, 0x0030.
- Order 4, k=15, samples 32767,-32768,32767,-32768,32767 → e=524280, u=1048560, q=31, r=0x7FF0.
  - Required fields: 16 zeros, then 15 zeros followed by a 1, then 0x7FF0 in 15 bits.
  - Check: no overflow; the decoder round-trips the sample.
- Order 0, k=0, residual zigzag u=40: 2 zero chunks, then a field of 9 bits (8 zeros and a 1) → verifies unary chunking and the boundary at q=16 exactly.
- iValid dropped for 5 cycles mid-block → no field, write or count change during the gap; output identical to the uninterrupted run.
- iRst low during RES_Q → all outputs return to reset values on the next edge; no oDone. A following iStart encodes a fresh block correctly.
